game_ctrl: RTL and testbench

Top-level game sequencer for the one-arm-bandit machine. Consumes player inputs (coin, lever start, stop) and the scoring block's pass/lose result pulses. Drives that scoring block with turn_p and score_reset, and feeds state, credit and LEDs to the display path. It is the initiator side of the turn_p -> pass_p/lose_p exchange.

---
 rtl/game_ctrl_pkg.sv | 25 ++
 rtl/game_ctrl_if.sv | 10 +
 rtl/gc_timer.sv | 26 ++
 rtl/game_ctrl.sv | 168 ++++++++++++++++
 tb/tb_game_ctrl.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/game_ctrl_pkg.sv
// Shared state codes and credit defaults for the bandit sequencer, scorer and display.
package game_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_WELCOME = 4'b0000,
    ST_GAME    = 4'b0001,
    ST_SCORE   = 4'b0010,
    ST_ERROR   = 4'b0011,
    ST_COIN    = 4'b0100
  } gc_state_e;

  localparam int unsigned MAX_CREDIT_DEF = 9;
  localparam int unsigned WIN_BONUS_DEF  = 2;
  localparam int unsigned TIMER_W        = 25;

  // Saturating credit add; the 5-bit sum keeps 4-bit credit from wrapping.
  function automatic logic [3:0] credit_add(input logic [3:0] c,
                                            input logic [3:0] inc,
                                            input logic [3:0] cap);
    logic [4:0] sum;
    sum = {1'b0, c} + {1'b0, inc};
    return (sum > {1'b0, cap}) ? cap : sum[3:0];
  endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// Sequencer <-> scorer exchange: turn request and score clear out, pass/lose results back.
interface game_ctrl_if;
  logic turn_p;
  logic score_reset;
  logic pass_p;
  logic lose_p;

  modport master (output turn_p, output score_reset, input pass_p, input lose_p);
  modport slave  (input turn_p, input score_reset, output pass_p, output lose_p);
endinterface

// File: rtl/gc_timer.sv
// Clearable saturating up-counter with terminal-count compare against a runtime value.
module gc_timer #(
  parameter int unsigned WIDTH = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [WIDTH-1:0] term,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (count != '1) begin
      count <= count + WIDTH'(1);
    end
  end

  assign tc = (count == term);

endmodule

// File: rtl/game_ctrl.sv
// One-arm-bandit game sequencer: credits, reel spin, scorer turn exchange and result hold.
module game_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int unsigned MAX_CREDIT     = MAX_CREDIT_DEF,
  parameter int unsigned WIN_BONUS      = WIN_BONUS_DEF,
  parameter int unsigned RESULT_TIMEOUT = 16,
  parameter int unsigned SHOW_CYCLES    = 25000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              coin_p,
  input  logic              start_p,
  input  logic              stop_p,
  input  logic              clear_p,
  game_ctrl_if.master       scr,
  output logic [3:0]        state,
  output logic              spin_en,
  output logic [3:0]        credit,
  output logic              win_led,
  output logic              lose_led,
  output logic              error
);

  localparam logic [3:0]         MAX_C     = 4'(MAX_CREDIT);
  localparam logic [3:0]         BONUS     = 4'(WIN_BONUS);
  localparam logic [TIMER_W-1:0] RESULT_TC = TIMER_W'(RESULT_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] SHOW_TC   = TIMER_W'(SHOW_CYCLES - 1);

  gc_state_e  state_q, state_d;
  logic [3:0] credit_q, credit_d;
  logic       hold_q, hold_d;
  logic       win_q, win_d;
  logic       lose_q, lose_d;
  logic       spin_q, spin_d;
  logic       err_q, err_d;
  logic       turn_q, turn_d;
  logic       srst_q, srst_d;

  logic               tmr_clr;
  logic               tmr_tc;
  logic [TIMER_W-1:0] tmr_term;

  // One timer serves both SCORE phases; it restarts on every state or phase change.
  assign tmr_term = hold_q ? SHOW_TC : RESULT_TC;

  gc_timer #(.WIDTH(TIMER_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .term  (tmr_term),
    .tc    (tmr_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_WELCOME;
      credit_q <= '0;
      hold_q   <= 1'b0;
      win_q    <= 1'b0;
      lose_q   <= 1'b0;
      spin_q   <= 1'b0;
      err_q    <= 1'b0;
      turn_q   <= 1'b0;
      srst_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      hold_q   <= hold_d;
      win_q    <= win_d;
      lose_q   <= lose_d;
      spin_q   <= spin_d;
      err_q    <= err_d;
      turn_q   <= turn_d;
      srst_q   <= srst_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    hold_d   = hold_q;
    win_d    = win_q;
    lose_d   = lose_q;
    turn_d   = 1'b0;
    srst_d   = 1'b0;

    if (clear_p) begin
      state_d  = ST_WELCOME;
      credit_d = '0;
      hold_d   = 1'b0;
      win_d    = 1'b0;
      lose_d   = 1'b0;
      srst_d   = 1'b1;
    end else begin
      unique case (state_q)
        ST_WELCOME: begin
          if (coin_p) begin
            credit_d = 4'd1;
            state_d  = ST_COIN;
          end
        end
        ST_COIN: begin
          if (start_p && (credit_q != '0)) begin
            credit_d = credit_q - 4'd1;
            state_d  = ST_GAME;
            win_d    = 1'b0;
            lose_d   = 1'b0;
          end else if (coin_p) begin
            if (credit_q < MAX_C) credit_d = credit_q + 4'd1;
            else                  state_d  = ST_ERROR;
          end
        end
        ST_GAME: begin
          if (stop_p) begin
            turn_d  = 1'b1;
            hold_d  = 1'b0;
            state_d = ST_SCORE;
          end
        end
        ST_SCORE: begin
          if (!hold_q) begin
            if (scr.pass_p && scr.lose_p) begin
              state_d = ST_ERROR;
            end else if (scr.pass_p) begin
              win_d    = 1'b1;
              credit_d = credit_add(credit_q, BONUS, MAX_C);
              hold_d   = 1'b1;
            end else if (scr.lose_p) begin
              lose_d = 1'b1;
              hold_d = 1'b1;
            end else if (tmr_tc) begin
              state_d = ST_ERROR;
            end
          end else if (tmr_tc) begin
            hold_d = 1'b0;
            if (credit_q != '0) begin
              state_d = ST_COIN;
            end else begin
              state_d = ST_WELCOME;
              srst_d  = 1'b1;
            end
          end
        end
        ST_ERROR: begin
          state_d = ST_ERROR;
        end
        default: begin
          state_d = ST_WELCOME;
        end
      endcase
    end

    spin_d  = (state_d == ST_GAME);
    err_d   = (state_d == ST_ERROR);
    tmr_clr = (state_d != state_q) || (hold_d != hold_q);
  end

  assign state           = state_q;
  assign credit          = credit_q;
  assign spin_en         = spin_q;
  assign win_led         = win_q;
  assign lose_led        = lose_q;
  assign error           = err_q;
  assign scr.turn_p      = turn_q;
  assign scr.score_reset = srst_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed vector bench for game_ctrl with shortened result and hold timers.
module tb_game_ctrl;
  import game_ctrl_pkg::*;

  // Input bit order: {coin, start, stop, clear, pass, lose}
  localparam logic [5:0] I_NONE  = 6'b000000;
  localparam logic [5:0] I_COIN  = 6'b100000;
  localparam logic [5:0] I_START = 6'b010000;
  localparam logic [5:0] I_STOP  = 6'b001000;
  localparam logic [5:0] I_CLR   = 6'b000100;
  localparam logic [5:0] I_PASS  = 6'b000010;
  localparam logic [5:0] I_LOSE  = 6'b000001;

  // Flag bit order: {turn, score_reset, spin, win, lose, error}
  localparam logic [5:0] F_NONE = 6'b000000;
  localparam logic [5:0] F_TURN = 6'b100000;
  localparam logic [5:0] F_SRST = 6'b010000;
  localparam logic [5:0] F_SPIN = 6'b001000;
  localparam logic [5:0] F_WIN  = 6'b000100;
  localparam logic [5:0] F_LOSE = 6'b000010;
  localparam logic [5:0] F_ERR  = 6'b000001;

  typedef struct {
    logic [5:0] in;
    logic [3:0] st;
    logic [3:0] cr;
    logic [5:0] fl;
    string      name;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic coin_p = 1'b0, start_p = 1'b0, stop_p = 1'b0, clear_p = 1'b0;
  logic [3:0] state, credit;
  logic spin_en, win_led, lose_led, error;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vq[$];

  game_ctrl_if gif ();

  game_ctrl #(.RESULT_TIMEOUT(8), .SHOW_CYCLES(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .coin_p   (coin_p),
    .start_p  (start_p),
    .stop_p   (stop_p),
    .clear_p  (clear_p),
    .scr      (gif),
    .state    (state),
    .spin_en  (spin_en),
    .credit   (credit),
    .win_led  (win_led),
    .lose_led (lose_led),
    .error    (error)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] outs();
    return {state, credit, gif.turn_p, gif.score_reset, spin_en, win_led, lose_led, error};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [5:0] in);
    {coin_p, start_p, stop_p, clear_p, gif.pass_p, gif.lose_p} = in;
  endtask

  task automatic step(input logic [5:0] in);
    set_in(in);
    @(posedge clk);
    #1;
    set_in(I_NONE);
  endtask

  task automatic add(input logic [5:0] in, input gc_state_e st, input logic [3:0] cr,
                     input logic [5:0] fl, input string name);
    vec_t v;
    v.in = in; v.st = st; v.cr = cr; v.fl = fl; v.name = name;
    vq.push_back(v);
  endtask

  initial begin
    set_in(I_NONE);

    // Win with bonus, hold, and simultaneous coin+start in COIN
    add(I_COIN,         ST_COIN,    4'd1, F_NONE,         "t1_coin1");
    add(I_COIN,         ST_COIN,    4'd2, F_NONE,         "t1_coin2");
    add(I_START,        ST_GAME,    4'd1, F_SPIN,         "t1_start");
    add(I_NONE,         ST_GAME,    4'd1, F_SPIN,         "t1_spin");
    add(I_STOP,         ST_SCORE,   4'd1, F_TURN,         "t1_turn");
    add(I_NONE,         ST_SCORE,   4'd1, F_NONE,         "t1_turn_off");
    add(I_NONE,         ST_SCORE,   4'd1, F_NONE,         "t1_wait");
    add(I_PASS,         ST_SCORE,   4'd3, F_WIN,          "t1_pass");
    add(I_NONE,         ST_SCORE,   4'd3, F_WIN,          "t1_hold1");
    add(I_PASS,         ST_SCORE,   4'd3, F_WIN,          "t1_hold_pass_ign");
    add(I_NONE,         ST_SCORE,   4'd3, F_WIN,          "t1_hold3");
    add(I_NONE,         ST_COIN,    4'd3, F_WIN,          "t1_to_coin");
    add(I_COIN|I_START, ST_GAME,    4'd2, F_SPIN,         "t5_coin_start");
    add(I_STOP,         ST_SCORE,   4'd2, F_TURN,         "t5_turn");
    add(I_NONE,         ST_SCORE,   4'd2, F_NONE,         "t5_wait");
    add(I_PASS|I_LOSE,  ST_ERROR,   4'd2, F_ERR,          "t5_both");
    add(I_COIN,         ST_ERROR,   4'd2, F_ERR,          "t5_err_sticky");
    add(I_CLR,          ST_WELCOME, 4'd0, F_SRST,         "t5_clear");
    add(I_NONE,         ST_WELCOME, 4'd0, F_NONE,         "t5_srst_off");
    // Lose to game over
    add(I_START,        ST_WELCOME, 4'd0, F_NONE,         "t2_start_ign");
    add(I_COIN,         ST_COIN,    4'd1, F_NONE,         "t2_coin");
    add(I_START,        ST_GAME,    4'd0, F_SPIN,         "t2_start");
    add(I_COIN,         ST_GAME,    4'd0, F_SPIN,         "t2_coin_ign");
    add(I_STOP,         ST_SCORE,   4'd0, F_TURN,         "t2_turn");
    add(I_NONE,         ST_SCORE,   4'd0, F_NONE,         "t2_wait");
    add(I_LOSE,         ST_SCORE,   4'd0, F_LOSE,         "t2_lose");
    add(I_NONE,         ST_SCORE,   4'd0, F_LOSE,         "t2_hold1");
    add(I_NONE,         ST_SCORE,   4'd0, F_LOSE,         "t2_hold2");
    add(I_NONE,         ST_SCORE,   4'd0, F_LOSE,         "t2_hold3");
    add(I_NONE,         ST_WELCOME, 4'd0, F_SRST|F_LOSE,  "t2_gameover");
    add(I_NONE,         ST_WELCOME, 4'd0, F_LOSE,         "t2_srst_off");
    // Credit saturation
    for (int unsigned i = 1; i <= 9; i++)
      add(I_COIN, ST_COIN, 4'(i), F_LOSE, $sformatf("t3_coin%0d", i));
    add(I_COIN,         ST_ERROR,   4'd9, F_ERR|F_LOSE,   "t3_overflow");
    add(I_CLR,          ST_WELCOME, 4'd0, F_SRST,         "t3_clear");

    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", 32'(outs()), 32'({ST_WELCOME, 4'd0, F_NONE}));
    rst_n = 1'b1;

    foreach (vq[i]) begin
      step(vq[i].in);
      check(vq[i].name, 32'(outs()), 32'({vq[i].st, vq[i].cr, vq[i].fl}));
    end

    // Result timeout: ERROR lands 8 cycles after SCORE entry
    step(I_COIN);
    step(I_START);
    step(I_STOP);
    check("t4_turn", 32'(outs()), 32'({ST_SCORE, 4'd0, F_TURN}));
    for (int k = 1; k <= 8; k++) begin
      step(I_NONE);
      check($sformatf("t4_wait%0d", k), 32'(state),
            32'((k < 8) ? ST_SCORE : ST_ERROR));
    end
    step(I_PASS);
    check("t4_late_pass", 32'(outs()), 32'({ST_ERROR, 4'd0, F_ERR}));
    step(I_CLR);
    check("t4_clear", 32'(outs()), 32'({ST_WELCOME, 4'd0, F_SRST}));

    // Asynchronous reset mid-GAME
    step(I_COIN);
    step(I_START);
    check("t6_game", 32'(outs()), 32'({ST_GAME, 4'd0, F_SPIN}));
    #3 rst_n = 1'b0;
    #1 check("t6_rst_game_async", 32'(outs()), 32'({ST_WELCOME, 4'd0, F_NONE}));
    @(posedge clk);
    #1 check("t6_rst_game_held", 32'(outs()), 32'({ST_WELCOME, 4'd0, F_NONE}));
    rst_n = 1'b1;

    // Reset while stop_p is pending: no turn_p may appear
    step(I_COIN);
    step(I_START);
    set_in(I_STOP);
    #3 rst_n = 1'b0;
    set_in(I_NONE);
    #1 check("t6_rst_stop_async", 32'(outs()), 32'({ST_WELCOME, 4'd0, F_NONE}));
    @(posedge clk);
    #1 check("t6_rst_stop_noturn", 32'(outs()), 32'({ST_WELCOME, 4'd0, F_NONE}));
    rst_n = 1'b1;

    // Asynchronous reset mid-SCORE
    step(I_COIN);
    step(I_START);
    step(I_STOP);
    check("t6_score", 32'(outs()), 32'({ST_SCORE, 4'd0, F_TURN}));
    #3 rst_n = 1'b0;
    #1 check("t6_rst_score_async", 32'(outs()), 32'({ST_WELCOME, 4'd0, F_NONE}));
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(I_LOSE);
    check("t6_after_reset", 32'(outs()), 32'({ST_WELCOME, 4'd0, F_NONE}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
